// File: rtl/gpio_bidirec_seq_if.sv
// Request/response bundle between a requester and the GPIO sequencer.
// Signal names follow the sequencer's point of view (_i = into sequencer).
// slave modport is the sequencer side, master modport is the requester side.
interface gpio_bidirec_seq_if;
   logic       req_valid_i;
   logic       req_ready_o;
   logic       req_wr_i;
   logic [7:0] req_data_i;
   logic       rsp_valid_o;
   logic [7:0] rsp_data_o;

   modport slave (
      input  req_valid_i, req_wr_i, req_data_i,
      output req_ready_o, rsp_valid_o, rsp_data_o
   );

   modport master (
      output req_valid_i, req_wr_i, req_data_i,
      input  req_ready_o, rsp_valid_o, rsp_data_o
   );
endinterface

// File: rtl/gpio_bidirec_seq.sv
// Purpose: sequences 8-bit read/write requests onto a bidirectional GPIO pad stage with turnaround gaps and a strobe.
// Latency: write TURN+HOLD cycles then ready; read response pulse in cycle TURN+HOLD+2 (TURN is 0 or TURNAROUND).
// Backpressure: req_ready_o is high only in IDLE; requests presented while busy are ignored, no queueing.
module gpio_bidirec_seq #(
   parameter int TURNAROUND = 2,
   parameter int HOLD       = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   gpio_bidirec_seq_if.slave   req,
   output logic [7:0]          din_o,
   output logic                in_not_out_o,
   output logic                strobe_o,
   input  logic [7:0]          dout_i
);

   localparam logic [7:0] TA_L   = 8'(TURNAROUND);
   localparam logic [7:0] HOLD_L = 8'(HOLD);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TURN,
      S_WRITE,
      S_READ,
      S_CAPTURE
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       drive_q, drive_d;     // 1 = last completed transfer left the bus driven
   logic       wr_q, wr_d;           // direction of the accepted request
   logic [7:0] wdata_q, wdata_d;     // write data captured at accept
   logic [7:0] din_q, din_d;
   logic [7:0] rsp_data_q, rsp_data_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       ready_c, inno_c, strobe_c;

   // State and datapath registers; async reset releases the bus and drops any in-flight request.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 8'd0;
         drive_q     <= 1'b0;
         wr_q        <= 1'b0;
         wdata_q     <= 8'd0;
         din_q       <= 8'd0;
         rsp_data_q  <= 8'd0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         drive_q     <= drive_d;
         wr_q        <= wr_d;
         wdata_q     <= wdata_d;
         din_q       <= din_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   // Next-state and pad-control decode; the counter is loaded on entry and the state exits when it reaches 1.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      drive_d     = drive_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      din_d       = din_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      ready_c     = 1'b0;
      inno_c      = 1'b1;
      strobe_c    = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_c = 1'b1;
            inno_c  = ~drive_q;      // a finished write keeps driving the bus
            cnt_d   = 8'd0;
            if (req.req_valid_i) begin
               wr_d    = req.req_wr_i;
               wdata_d = req.req_data_i;
               // Direction change needs a released gap unless turnaround is disabled.
               if ((req.req_wr_i != drive_q) && (TA_L != 8'd0)) begin
                  state_d = S_TURN;
                  cnt_d   = TA_L;
               end else begin
                  cnt_d = HOLD_L;
                  if (req.req_wr_i) begin
                     state_d = S_WRITE;
                     din_d   = req.req_data_i;
                  end else begin
                     state_d = S_READ;
                  end
               end
            end
         end
         S_TURN: begin
            if (cnt_q == 8'd1) begin
               cnt_d = HOLD_L;
               if (wr_q) begin
                  state_d = S_WRITE;
                  din_d   = wdata_q;
               end else begin
                  state_d = S_READ;
               end
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_WRITE: begin
            inno_c   = 1'b0;
            strobe_c = (cnt_q != HOLD_L);   // first write cycle is data setup only
            drive_d  = 1'b1;
            if (cnt_q == 8'd1) begin
               state_d = S_IDLE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_READ: begin
            strobe_c = 1'b1;
            drive_d  = 1'b0;
            if (cnt_q == 8'd1) begin
               state_d = S_CAPTURE;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_CAPTURE: begin
            // dout_i now carries the pad value of the last READ cycle.
            rsp_data_d  = dout_i;
            rsp_valid_d = 1'b1;
            state_d     = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = 8'd0;
         end
      endcase
   end

   assign req.req_ready_o = ready_c;
   assign req.rsp_valid_o = rsp_valid_q;
   assign req.rsp_data_o  = rsp_data_q;
   assign din_o           = din_q;
   assign in_not_out_o    = inno_c;
   assign strobe_o        = strobe_c;

endmodule

// File: tb/tb_gpio_bidirec_seq.sv
// Bench for gpio_bidirec_seq: directed test-plan scenarios, then random traffic.
// The driver expands each request into a per-cycle list of expected pad/handshake values;
// a negedge monitor pops one entry per cycle and checks read responses against a data queue.
module tb_gpio_bidirec_seq;

   localparam int TA = 2;
   localparam int HD = 4;

   typedef struct packed {
      logic       rdy;
      logic       inno;
      logic       stb;
      logic       rv;
      logic [7:0] din;
      logic [7:0] rd;
   } rec_t;

   logic       clk;
   logic       rst_n;
   logic [7:0] din;
   logic       inno;
   logic       strobe;
   logic [7:0] dout;

   gpio_bidirec_seq_if bus();

   gpio_bidirec_seq #(.TURNAROUND(TA), .HOLD(HD)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (bus.slave),
      .din_o        (din),
      .in_not_out_o (inno),
      .strobe_o     (strobe),
      .dout_i       (dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   bit         mon_en   = 0;
   rec_t       exp_q[$];
   logic [7:0] rsp_q[$];

   // Reference model state: what the outside world should see between transfers.
   bit         m_drive;
   logic [7:0] m_din;
   logic [7:0] m_rsp;
   bit         m_pend;

   task automatic model_reset();
      m_drive = 0;
      m_din   = 8'h00;
      m_rsp   = 8'h00;
      m_pend  = 0;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic push_idle();
      rec_t r;
      r = '{rdy: 1'b1, inno: ~m_drive, stb: 1'b0, rv: m_pend, din: m_din, rd: m_rsp};
      exp_q.push_back(r);
      m_pend = 0;
   endtask

   // Expected cycles 1..N following the accept edge.
   task automatic push_trace(input bit wr, input logic [7:0] data, input logic [7:0] pad);
      int turn;
      rec_t r;
      turn = ((wr != m_drive) && (TA > 0)) ? TA : 0;
      for (int i = 0; i < turn; i++) begin
         r = '{rdy: 1'b0, inno: 1'b1, stb: 1'b0, rv: 1'b0, din: m_din, rd: m_rsp};
         exp_q.push_back(r);
      end
      if (wr) begin
         for (int k = 0; k < HD; k++) begin
            r = '{rdy: 1'b0, inno: 1'b0, stb: (k > 0), rv: 1'b0, din: data, rd: m_rsp};
            exp_q.push_back(r);
         end
         m_din   = data;
         m_drive = 1;
      end else begin
         for (int k = 0; k < HD; k++) begin
            r = '{rdy: 1'b0, inno: 1'b1, stb: 1'b1, rv: 1'b0, din: m_din, rd: m_rsp};
            exp_q.push_back(r);
         end
         r = '{rdy: 1'b0, inno: 1'b1, stb: 1'b0, rv: 1'b0, din: m_din, rd: m_rsp};
         exp_q.push_back(r);
         m_drive = 0;
         m_rsp   = pad;
         m_pend  = 1;
         rsp_q.push_back(pad);
      end
   endtask

   // Called at posedge+1 of an idle cycle.
   task automatic idle_cycle();
      push_idle();
      bus.req_valid_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 600) begin
         @(posedge clk); #1;
         guard++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain_timeout: actual %0d entries left required 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic issue(input bit wr, input logic [7:0] data, input logic [7:0] pad, input bit hold);
      push_idle();
      bus.req_valid_i = 1'b1;
      bus.req_wr_i    = wr;
      bus.req_data_i  = data;
      dout            = pad;
      push_trace(wr, data, pad);
      @(posedge clk); #1;
      if (hold) begin
         // Keep valid asserted with junk contents; it must be ignored until ready.
         bus.req_wr_i   = 1'($urandom);
         bus.req_data_i = 8'($urandom);
      end else begin
         bus.req_valid_i = 1'b0;
      end
      wait_drain();
   endtask

   // Per-cycle monitor: one expected entry per cycle, plus response data on each pulse.
   always @(negedge clk) begin
      if (mon_en) begin
         rec_t a, e;
         a = '{rdy: bus.req_ready_o, inno: inno, stb: strobe, rv: bus.rsp_valid_o,
               din: din, rd: bus.rsp_data_o};
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL cycle_underflow at %0t: actual %h required an expected entry", $time, a);
         end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
               n_fail++;
               $display("FAIL cycle at %0t: actual rdy=%b inno=%b stb=%b rv=%b din=%h rd=%h required rdy=%b inno=%b stb=%b rv=%b din=%h rd=%h",
                        $time, a.rdy, a.inno, a.stb, a.rv, a.din, a.rd,
                        e.rdy, e.inno, e.stb, e.rv, e.din, e.rd);
            end
         end
         if (bus.rsp_valid_o === 1'b1) begin
            n_checks++;
            if (rsp_q.size() == 0) begin
               n_fail++;
               $display("FAIL rsp_unexpected at %0t: actual %h required no response", $time, bus.rsp_data_o);
            end else begin
               logic [7:0] er;
               er = rsp_q.pop_front();
               if (bus.rsp_data_o !== er) begin
                  n_fail++;
                  $display("FAIL rsp_data at %0t: actual %h required %h", $time, bus.rsp_data_o, er);
               end
            end
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      bus.req_valid_i = 1'b0;
      bus.req_wr_i    = 1'b0;
      bus.req_data_i  = 8'h00;
      dout            = 8'h00;
      model_reset();

      // Reset values while held in reset.
      repeat (2) @(posedge clk);
      #3;
      check("rst_inno",   32'(inno), 32'd1);
      check("rst_strobe", 32'(strobe), 32'd0);
      check("rst_din",    32'(din), 32'h00);
      check("rst_rspv",   32'(bus.rsp_valid_o), 32'd0);
      check("rst_rspd",   32'(bus.rsp_data_o), 32'h00);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_ready",  32'(bus.req_ready_o), 32'd1);

      mon_en = 1;
      idle_cycle();
      // Test-plan sequence.
      issue(1'b1, 8'hA5, 8'h00, 1'b0);   // first write: TURN path
      issue(1'b1, 8'h3C, 8'h00, 1'b0);   // back-to-back write: no TURN
      issue(1'b0, 8'h00, 8'h5A, 1'b0);   // read while driving
      issue(1'b0, 8'h00, 8'hC3, 1'b1);   // read after read, valid held high
      repeat (3) idle_cycle();           // rsp_data holds C3, no extra accepts

      // Random traffic.
      for (int t = 0; t < 120; t++) begin
         int gap;
         gap = int'($urandom_range(0, 2));
         for (int g = 0; g < gap; g++) idle_cycle();
         issue(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      // Reset during READ cycle 3 of a read-after-read.
      issue(1'b0, 8'h00, 8'h77, 1'b0);
      push_idle();
      bus.req_valid_i = 1'b1;
      bus.req_wr_i    = 1'b0;
      dout            = 8'h99;
      push_trace(1'b0, 8'h00, 8'h99);
      @(posedge clk); #1;                // cycle 1
      bus.req_valid_i = 1'b0;
      @(posedge clk); #1;                // cycle 2
      @(posedge clk); #1;                // cycle 3
      mon_en = 0;
      check("pre_rst_strobe", 32'(strobe), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_inno",   32'(inno), 32'd1);
      check("mid_rst_strobe", 32'(strobe), 32'd0);
      check("mid_rst_din",    32'(din), 32'h00);
      check("mid_rst_rspv",   32'(bus.rsp_valid_o), 32'd0);
      check("mid_rst_rspd",   32'(bus.rsp_data_o), 32'h00);
      exp_q.delete();
      rsp_q.delete();
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      mon_en = 1;
      repeat (4) idle_cycle();           // no response pulse after reset
      issue(1'b1, 8'h11, 8'h00, 1'b0);   // TURN path again, first drive in cycle 3
      repeat (2) idle_cycle();
      mon_en = 0;

      check("rsp_left", 32'(rsp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
